// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side controller for a byte FIFO with registered read data. A start
//   command pops exactly len bytes and presents them on a valid/ready stream.
//   A 2-entry skid buffer absorbs the FIFO's one-cycle read latency, so the
//   stream runs at one byte per cycle and loses nothing under backpressure.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start, len          burst request and its length, taken only while idle
//   busy, done          state != IDLE; one-cycle pulse when a burst completes
//   fifo_empty          FIFO empty flag
//   fifo_data           FIFO read data, valid the cycle after a pop
//   fifo_rd_en          FIFO pop request (combinational)
//   m_data, m_valid     output stream; m_data is 0 while the buffer is empty
//   m_ready             downstream accept
//   rd_count            bytes handed off in the current or last burst
module fifo_burst_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LEN_W-1:0]  rd_count
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              done_nxt;
    logic [LEN_W-1:0]  req_left;
    logic              inflight;
    logic [DATA_W-1:0] buf0;      // head entry
    logic [DATA_W-1:0] buf1;
    logic [1:0]        buf_cnt;
    logic              hs;
    logic [2:0]        occ;

    always_comb begin
        busy    = (state != IDLE);
        m_valid = (buf_cnt != 2'd0);
        m_data  = m_valid ? buf0 : '0;
        hs      = m_valid && m_ready;
        // Slots still committed once this cycle's handshake retires; a new
        // pop is allowed only if its byte will find room when it lands.
        occ     = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, hs};
    end

    always_comb begin
        state_nxt  = state;
        done_nxt   = 1'b0;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_nxt = READ;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            READ: begin
                fifo_rd_en = !fifo_empty && (req_left != '0) && (occ < 3'd2);
                if (fifo_rd_en && (req_left == LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // No pops remain, so the last byte is the sole buffered
                // entry with nothing still in flight.
                if (hs && (buf_cnt == 2'd1) && !inflight) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            req_left <= '0;
            rd_count <= '0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
            buf_cnt  <= 2'd0;
        end else begin
            state    <= state_nxt;
            done     <= done_nxt;
            inflight <= fifo_rd_en;

            if ((state == IDLE) && start && (len != '0)) begin
                req_left <= len;
                rd_count <= '0;
            end else begin
                if (fifo_rd_en) begin
                    req_left <= req_left - LEN_W'(1);
                end
                if (hs) begin
                    rd_count <= rd_count + LEN_W'(1);
                end
            end

            case ({inflight, hs})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf0 <= fifo_data;
                    end else begin
                        buf1 <= fifo_data;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    // Push and pop together: count unchanged, order kept.
                    if (buf_cnt == 2'd1) begin
                        buf0 <= fifo_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: a queue-based FIFO model feeds the DUT,
// the stimulus process records expected byte indices and burst lengths, and
// an independent monitor checks every handshake, done pulse and protocol rule.
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] rd_count;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_W(8), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .rd_count   (rd_count)
    );

    // FIFO model: bytes written by the stimulus in order, popped by rd_en
    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected byte indices into mem and accepted burst lengths
    int exp_q[$];
    int len_q[$];
    int next_idx = 0;

    // Monitor state
    bit         in_burst = 0;
    bit         done_due = 0;
    bit         valid_seen = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    int cur_len = 0;
    int hs_cnt = 0;
    int pops = 0;
    int pops_tot = 0;
    int hs_tot = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc = 0;
    int first_hs_cyc = 0;
    int last_hs_cyc = 0;

    always @(negedge clk) begin
        bit nd;
        int idx;
        nd = 0;
        if (rst) begin
            exp_q.delete();
            len_q.delete();
            in_burst = 0;
            done_due = 0;
            prev_stall = 0;
            hs_cnt = 0;
            pops_tot = 0;
            hs_tot = 0;
        end else begin
            if (done || done_due) check("done_pulse", done, done_due);
            if (done && done_due && cur_len != 0) check("rd_count_final", rd_count, cur_len);
            if (busy) check("occupancy_le2", (pops_tot - hs_tot) <= 2, 1);
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
            end
            if (fifo_rd_en) check("rd_en_while_empty", fifo_empty, 0);
            if (fifo_rd_en && !fifo_empty) begin
                check("pop_inside_burst", in_burst, 1);
                if (pops == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pops++;
                pops_tot++;
            end
            if (start && !busy) begin
                if (len_q.size() == 0) begin
                    check("unexpected_accept", 1, 0);
                    cur_len = len;
                end else begin
                    cur_len = len_q.pop_front();
                end
                hs_cnt = 0;
                pops = 0;
                valid_seen = 0;
                if (cur_len == 0) nd = 1;
                else in_burst = 1;
            end
            if (m_valid) begin
                check("valid_inside_burst", in_burst, 1);
                if (!valid_seen) begin
                    valid_seen = 1;
                    check("first_valid_latency", cyc - first_pop_cyc, 2);
                end
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 1, 0);
                end else begin
                    idx = exp_q.pop_front();
                    check("m_data", m_data, mem[idx]);
                end
                check("rd_count_step", rd_count, hs_cnt);
                if (hs_cnt == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_cnt++;
                hs_tot++;
                if (in_burst && hs_cnt == cur_len) begin
                    in_burst = 0;
                    nd = 1;
                    check("pops_per_burst", pops, cur_len);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
        done_due = nd;
    end

    // Stimulus helpers
    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic start_burst(input int l);
        start = 1'b1;
        len   = l[7:0];
        len_q.push_back(l);
        for (int k = 0; k < l; k++) begin
            exp_q.push_back(next_idx);
            next_idx++;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready held high; 1: fixed stall pattern; 2: random ready + writes
    task automatic wait_done(input int mode, input int late_at, input int late_n, input int budget);
        logic [7:0] pat;
        bit ok;
        int p;
        pat = 8'b1110_1001;
        ok = 0;
        p = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1;
                break;
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (p < 8) ? pat[p] : 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_valid) p++;
            if (mode == 2 && $urandom_range(0, 1) == 1) push_byte(8'($urandom_range(0, 255)));
            if (i == late_at) begin
                for (int k = 0; k < late_n; k++) push_byte(8'hC2 + 8'(k));
            end
            @(posedge clk); #1;
        end
        check("done_within_budget", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b1;
        len = 8'd5;
        m_ready = 1'b0;

        // 1. reset with start held high
        repeat (2) begin @(posedge clk); #1; end
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", m_valid, 0);
        check("reset_rd_en", fifo_rd_en, 0);
        check("reset_rd_count", rd_count, 0);
        check("reset_m_data", m_data, 0);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", busy, 0);

        // 2. streaming with ready held high
        for (int k = 0; k < 5; k++) push_byte(8'h11 + 8'(k));
        m_ready = 1'b1;
        start_burst(4);
        wait_done(0, -1, 0, 100);
        check("stream_pop_span", last_pop_cyc - first_pop_cyc, 3);
        check("stream_hs_span", last_hs_cyc - first_hs_cyc, 3);
        check("stream_rd_count", rd_count, 4);
        check("stream_fifo_left", wr_ptr - rd_ptr, 1);
        check("stream_fifo_head", mem[rd_ptr], 8'h15);
        start_burst(1);
        wait_done(0, -1, 0, 100);

        // 3. backpressure pattern
        for (int k = 0; k < 6; k++) push_byte(8'hA0 + 8'(k));
        start_burst(6);
        wait_done(1, -1, 0, 200);
        check("bp_rd_count", rd_count, 6);
        check("bp_fifo_drained", wr_ptr - rd_ptr, 0);

        // 4. empty stall, two more bytes arrive later
        m_ready = 1'b1;
        push_byte(8'hC0);
        push_byte(8'hC1);
        start_burst(4);
        wait_done(0, 5, 2, 200);
        check("stall_rd_count", rd_count, 4);

        // 5. zero length, then start ignored while busy
        start_burst(0);
        check("zero_len_done_next", done, 1);
        check("zero_len_busy", busy, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) push_byte(8'h50 + 8'(k));
        m_ready = 1'b0;
        start_burst(5);
        @(posedge clk); #1;
        check("busy_during_burst", busy, 1);
        start = 1'b1;
        len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0, -1, 0, 200);
        check("ignored_start_rd_count", rd_count, 5);
        @(posedge clk); #1;
        check("idle_after_len5", busy, 0);

        // 6. reset mid-burst after three handshakes
        for (int k = 0; k < 8; k++) push_byte(8'h70 + 8'(k));
        m_ready = 1'b1;
        start_burst(8);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 100; i++) begin
                if (hs_cnt >= 3) begin
                    seen = 1;
                    break;
                end
                @(posedge clk); #1;
            end
            check("three_handshakes_seen", seen, 1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        next_idx = rd_ptr;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_valid", m_valid, 0);
        check("midrst_rd_en", fifo_rd_en, 0);
        check("midrst_rd_count", rd_count, 0);
        @(posedge clk); #1;
        check("midrst_no_done", done, 0);
        if (wr_ptr - rd_ptr < 2) begin
            push_byte(8'h90);
            push_byte(8'h91);
        end
        start_burst(2);
        wait_done(0, -1, 0, 100);
        check("post_rst_rd_count", rd_count, 2);

        // random bursts with random ready and random FIFO arrivals
        for (int b = 0; b < 8; b++) begin
            int l;
            l = $urandom_range(1, 12);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) push_byte(8'($urandom_range(0, 255)));
            start_burst(l);
            wait_done(2, -1, 0, 800);
            check("rand_rd_count", rd_count, l);
        end

        m_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("final_idle", busy, 0);
        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side controller for the team's byte FIFO. On a start command it pops exactly len bytes from the FIFO and presents them on a valid/ready output stream. A 2-entry skid buffer absorbs the FIFO's one-cycle registered read latency, so throughput is one byte per cycle with no loss under backpressure. It sits between the FIFO's out/rd_en/empty port and any downstream byte consumer, such as a serializer or packet builder.

Parameters:
DATA_W, 8, width of FIFO data and stream data
LEN_W, 8, width of burst length and delivered-byte counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  burst request, accepted only in IDLE
len  input  LEN_W  burst length in bytes, sampled when start is accepted
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when the burst completes
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_W  FIFO registered read data
fifo_rd_en  output  1  FIFO pop request (combinational)
m_data  output  DATA_W  stream data
m_valid  output  1  stream data valid
m_ready  input  1  downstream accept
rd_count  output  LEN_W  bytes handed off in the current or last burst

Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.
- FIFO contract: if fifo_rd_en=1 while fifo_empty=0 in cycle t, fifo_data holds the popped byte throughout cycle t+1.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, fifo_rd_en=0, m_valid=0, m_data=0, rd_count=0; buffer, in-flight flag and request counter cleared. All happen at the rising edge where rst=1.
- Reset mid-burst: the burst is aborted. Buffered and in-flight bytes are discarded and lost. No done pulse.
- States:
  - IDLE: start=1 and len!=0 -> READ. Load req_left=len, clear rd_count.
  - IDLE: start=1 and len==0 -> stay IDLE. done=1 in the next cycle. No FIFO access.
  - READ: when the last pop is issued (req_left reaches 0) -> DRAIN.
  - DRAIN: when the last byte is handshaked -> IDLE. done=1 in the following cycle.
  - start is ignored while busy.
- inflight register = fifo_rd_en registered. When inflight=1, fifo_data is written into the skid buffer at the end of that cycle.
- Skid buffer: 2-entry FIFO, count buf_cnt in 0..2.
  - m_valid = (buf_cnt != 0).
  - m_data = head entry; 0 when the buffer is empty.
- Pop issue rule: fifo_rd_en = (state==READ) && !fifo_empty && (req_left!=0) && (buf_cnt + inflight - (m_valid&&m_ready)) < 2.
  - fifo_rd_en is never asserted while fifo_empty=1.
  - The buffer never overflows.
- Latency: first fifo_rd_en in cycle t -> first m_valid in cycle t+2.
- Throughput: with m_ready held at 1 and the FIFO non-empty, one pop and one handshake per cycle.
- Backpressure: while m_valid=1 and m_ready=0, m_data holds stable. Byte order matches pop order.
- Handshake: m_valid && m_ready. Each handshake increments rd_count, which holds its final value after done.
- Simultaneous push and pop on the skid buffer in the same cycle: buf_cnt is unchanged and order is preserved.
- Counters wrap never: req_left only decrements from len to 0, and rd_count never exceeds len.

Test Plan:
1. Reset: assert rst for 2 cycles with start=1 -> busy=0, done=0, m_valid=0, fifo_rd_en=0, rd_count=0.
2. Streaming: FIFO preloaded 0x11..0x15, start len=4, m_ready=1 -> fifo_rd_en high for exactly 4 consecutive cycles; m_data=0x11,0x12,0x13,0x14 on 4 consecutive cycles beginning 2 cycles after the first pop; done pulses once; rd_count=4; 0x15 remains in the FIFO.
3. Backpressure: 6 bytes 0xA0..0xA5, len=6, m_ready pattern 1,0,0,1,0,1,1,1,... -> every byte delivered once and in order; m_data stable during stalls; buf_cnt+inflight never exceeds 2; done after the 6th handshake.
4. Empty stall: FIFO holds 2 bytes, len=4, 2 more bytes written 5 cycles later -> fifo_rd_en=0 while fifo_empty=1; the burst resumes; 4 bytes delivered in order; done once.
5. Zero length and start while busy: start len=0 -> done next cycle, no fifo_rd_en. start len=3 during an active len=5 burst -> ignored; rd_count=5.
6. Reset mid-burst: len=8, rst asserted after 3 handshakes -> IDLE next cycle, all outputs at reset values, no done pulse. A subsequent start len=2 works normally.
